// File: rtl/nibble_serial_add16.sv
// Multi-cycle WIDTH-bit unsigned adder: one SLICE-bit ripple slice per clock, with the carry
// registered between slices. Operands enter through a start/busy handshake; done pulses for one cycle.
module nibble_serial_add16 #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;
  logic [IW-1:0]    idx;
  logic [SLICE-1:0] x, y, s;
  logic [SLICE:0]   c;
  logic             accept;

  // One ripple slice built from full adders, fed by the registered carry
  always_comb begin
    x    = a_r[idx*SLICE +: SLICE];
    y    = b_r[idx*SLICE +: SLICE];
    s    = '0;
    c    = '0;
    c[0] = carry_r;
    for (int unsigned i = 0; i < SLICE; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        accept = start;
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        accept     = start;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // sum is written slice by slice, so it keeps the previous result until the first RUN edge
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum[idx*SLICE +: SLICE] <= s;
      carry_r                 <= c[SLICE];
      idx                     <= idx + 1'b1;
      if (idx == LAST) cout <= c[SLICE];
    end
  end

endmodule

// File: tb/tb_nibble_serial_add16.sv
// Bench for nibble_serial_add16: directed vector table, handshake corner cases and random
// operands, with results checked through an expected-result queue on every done pulse.
module tb_nibble_serial_add16;

  logic        clk = 1'b0;
  logic        rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout;
  logic [15:0] sum;

  nibble_serial_add16 #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [16:0] sbq[$];
  logic [16:0] mon_e;
  logic [15:0] prev_sum;
  logic        prev_cout;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  // Every done pulse pops one expected {cout,sum}
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("sum", {16'd0, sum}, {16'd0, mon_e[15:0]});
        chk("cout", {31'd0, cout}, {31'd0, mon_e[16]});
      end
    end
  end

  // Called 1 time unit after an edge with the DUT idle
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                       input logic [16:0] ex);
    int d0;
    a = ta; b = tb2; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sbq.push_back(ex);
    d0 = done_cnt;
    chk("sum_hold_on_accept", {16'd0, sum}, {16'd0, prev_sum});
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("busy_run", {30'd0, done, busy}, 32'd1);
      chk("cout_hold", {31'd0, cout}, {31'd0, prev_cout});
      @(posedge clk); #1;
    end
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
    @(posedge clk); #1;
    chk("idle_after", {30'd0, done, busy}, 32'd0);
    chk("done_count", done_cnt, d0 + 1);
    prev_sum  = ex[15:0];
    prev_cout = ex[16];
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ba[3];
    logic [15:0] bb[3];
    logic        bc[3];
    logic [15:0] ra, rb;
    logic        rc;
    int          d0;

    tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
    tbl[1] = '{16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b0};
    tbl[2] = '{16'h0007, 16'h0009, 1'b1, 16'h0011, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[4] = '{16'h9111, 16'h8765, 1'b0, 16'h1876, 1'b1};

    rst = 1'b1; start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_done", {30'd0, done, busy}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0; start = 1'b0;
    prev_sum = 16'h0000; prev_cout = 1'b0;

    for (int i = 0; i < 5; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].co, tbl[i].s});

    // Abort on the second RUN cycle; sum=1876/cout=1 from the last vector must clear
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy_done", {30'd0, done, busy}, 32'd0);
    chk("abort_sum", {16'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", {30'd0, done, busy}, 32'd0);
    prev_sum = 16'h0000; prev_cout = 1'b0;

    // start held while busy, with new operands on the bus, must be ignored
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    sbq.push_back(17'h02345);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_busy", {30'd0, done, busy}, 32'd1);
      if (i == 2) start = 1'b0;
      @(posedge clk); #1;
    end
    chk("ign_done", {30'd0, done, busy}, 32'd2);
    @(posedge clk); #1;
    chk("ign_idle", {30'd0, done, busy}, 32'd0);
    chk("ign_count", done_cnt, d0 + 1);
    prev_sum = 16'h2345; prev_cout = 1'b0;

    // Back-to-back with start held: acceptance and done every 5 cycles
    ba[0] = 16'h1111; bb[0] = 16'h2222; bc[0] = 1'b0;
    ba[1] = 16'hFFFF; bb[1] = 16'h0001; bc[1] = 1'b0;
    ba[2] = 16'h8000; bb[2] = 16'h8000; bc[2] = 1'b1;
    a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
    d0 = done_cnt;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      sbq.push_back(model(ba[j], bb[j], bc[j]));
      chk("b2b_accept", {30'd0, done, busy}, 32'd1);
      if (j < 2) begin
        a = ba[j+1]; b = bb[j+1]; cin = bc[j+1];
      end else begin
        start = 1'b0;
      end
      repeat (3) begin
        @(posedge clk); #1;
        chk("b2b_run", {30'd0, done, busy}, 32'd1);
      end
      @(posedge clk); #1;
      chk("b2b_done", {30'd0, done, busy}, 32'd2);
    end
    @(posedge clk); #1;
    chk("b2b_idle", {30'd0, done, busy}, 32'd0);
    chk("b2b_count", done_cnt, d0 + 3);
    prev_sum = 16'h0001; prev_cout = 1'b1;

    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (n % 50 == 0) rb = ~ra;
      do_op(ra, rb, rc, model(ra, rb, rc));
    end

    chk("queue_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
